// File: rtl/pipe_mac_rx_receiver.sv
// PIPE MAC receive path: COM symbol lock, SKP stripping, error accounting and a FWFT output FIFO.
// Optional macro PIPE_MAC_RX_LAST_ERR_EN adds the Last_Err_Status output.
module pipe_mac_rx_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int LOCK_COM_COUNT = 2,
  parameter int ERR_LIMIT      = 4
) (
  input  logic       PCLK,
  input  logic       Reset,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_DataK,
  input  logic       Rx_Valid,
  input  logic [2:0] Rx_Status,
  output logic [7:0] Out_Data,
  output logic       Out_DataK,
  output logic       Out_Valid,
  input  logic       Out_Ready,
`ifdef PIPE_MAC_RX_LAST_ERR_EN
  output logic [2:0] Last_Err_Status,
`endif
  output logic       Locked,
  output logic [15:0] Err_Count,
  output logic       Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    LOCK_N  = 4'(LOCK_COM_COUNT);
  localparam logic [3:0]    ERR_N   = 4'(ERR_LIMIT);
  localparam logic [CW-1:0] DEPTH_N = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [3:0]  com_cnt_r, com_cnt_s;
  logic [3:0]  err_run_r, err_run_s;

  logic        good_s, err_s, com_s, skp_s;
  logic        wr_s, rd_s, full_s, wr_acc_s;

  logic [8:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [15:0]   err_cnt_r;
  logic          ovf_r;

  // Symbol classification
  always_comb begin
    good_s = 1'b0;
    err_s  = 1'b0;
    case (Rx_Status)
      3'b000, 3'b001, 3'b010: good_s = Rx_Valid;
      3'b100, 3'b101, 3'b110, 3'b111: err_s = Rx_Valid;
      default: begin
        good_s = 1'b0;
        err_s  = 1'b0;
      end
    endcase
    com_s = good_s & Rx_DataK & (Rx_Data == 8'hBC);
    skp_s = good_s & Rx_DataK & (Rx_Data == 8'h1C);
  end

  // Lock FSM next-state and counter updates
  always_comb begin
    state_s   = state_r;
    com_cnt_s = com_cnt_r;
    err_run_s = err_run_r;
    case (state_r)
      UNLOCKED: begin
        if (com_s) begin
          if ((com_cnt_r + 4'd1) == LOCK_N) begin
            state_s   = LOCKED;
            com_cnt_s = 4'd0;
            err_run_s = 4'd0;
          end else begin
            com_cnt_s = com_cnt_r + 4'd1;
          end
        end else if (err_s || !Rx_Valid) begin
          com_cnt_s = 4'd0;
        end else begin
          com_cnt_s = com_cnt_r;
        end
      end
      LOCKED: begin
        if (!Rx_Valid) begin
          state_s = UNLOCKED;
        end else if (err_s) begin
          err_run_s = err_run_r + 4'd1;
          if ((err_run_r + 4'd1) == ERR_N) begin
            state_s = UNLOCKED;
          end else begin
            state_s = LOCKED;
          end
        end else if (com_s) begin
          err_run_s = 4'd0;
        end else begin
          err_run_s = err_run_r;
        end
      end
      default: begin
        state_s   = UNLOCKED;
        com_cnt_s = 4'd0;
        err_run_s = 4'd0;
      end
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge PCLK or posedge Reset) begin
    if (Reset) begin
      state_r   <= UNLOCKED;
      com_cnt_r <= 4'd0;
      err_run_r <= 4'd0;
    end else begin
      state_r   <= state_s;
      com_cnt_r <= com_cnt_s;
      err_run_r <= err_run_s;
    end
  end

  // A read in the same cycle frees a slot, so a full FIFO still accepts the write
  always_comb begin
    wr_s     = (state_r == LOCKED) & good_s & ~skp_s;
    full_s   = (count_r == DEPTH_N);
    rd_s     = Out_Valid & Out_Ready;
    wr_acc_s = wr_s & (~full_s | rd_s);
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge PCLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      else          wr_ptr_r <= wr_ptr_r;
      if (rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      else      rd_ptr_r <= rd_ptr_r;
      if (wr_acc_s && !rd_s)      count_r <= count_r + CW'(1);
      else if (rd_s && !wr_acc_s) count_r <= count_r - CW'(1);
      else                        count_r <= count_r;
      if (wr_s && full_s && !rd_s) ovf_r <= 1'b1;
      else                         ovf_r <= ovf_r;
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge PCLK) begin
    if (wr_acc_s) mem_r[wr_ptr_r] <= {Rx_DataK, Rx_Data};
  end

  // Saturating error counter
  always_ff @(posedge PCLK or posedge Reset) begin
    if (Reset) begin
      err_cnt_r <= 16'h0000;
    end else if (err_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

`ifdef PIPE_MAC_RX_LAST_ERR_EN
  logic [2:0] last_err_r;

  // Capture status of the most recent errored symbol
  always_ff @(posedge PCLK or posedge Reset) begin
    if (Reset)      last_err_r <= 3'b000;
    else if (err_s) last_err_r <= Rx_Status;
    else            last_err_r <= last_err_r;
  end

  assign Last_Err_Status = last_err_r;
`endif

  // Head is masked while empty so the data outputs read zero after reset
  assign Out_Valid = (count_r != {CW{1'b0}});
  assign Out_Data  = Out_Valid ? mem_r[rd_ptr_r][7:0] : 8'h00;
  assign Out_DataK = Out_Valid ? mem_r[rd_ptr_r][8]   : 1'b0;
  assign Locked    = (state_r == LOCKED);
  assign Err_Count = err_cnt_r;
  assign Overflow  = ovf_r;

endmodule

// File: tb/tb_pipe_mac_rx_receiver.sv
// Scoreboard bench for pipe_mac_rx_receiver: directed symbol streams, monitor pops expected FIFO output.
module tb_pipe_mac_rx_receiver;

  logic        PCLK = 1'b0;
  logic        Reset;
  logic [7:0]  Rx_Data;
  logic        Rx_DataK;
  logic        Rx_Valid;
  logic [2:0]  Rx_Status;
  logic [7:0]  Out_Data;
  logic        Out_DataK;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Locked;
  logic [15:0] Err_Count;
  logic        Overflow;
`ifdef PIPE_MAC_RX_LAST_ERR_EN
  logic [2:0]  Last_Err_Status;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  pipe_mac_rx_receiver #(.FIFO_DEPTH(8), .LOCK_COM_COUNT(2), .ERR_LIMIT(4)) dut (
    .PCLK(PCLK), .Reset(Reset),
    .Rx_Data(Rx_Data), .Rx_DataK(Rx_DataK), .Rx_Valid(Rx_Valid), .Rx_Status(Rx_Status),
    .Out_Data(Out_Data), .Out_DataK(Out_DataK), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
`ifdef PIPE_MAC_RX_LAST_ERR_EN
    .Last_Err_Status(Last_Err_Status),
`endif
    .Locked(Locked), .Err_Count(Err_Count), .Overflow(Overflow)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one symbol just after an edge; returns just after the edge that samples it
  task automatic sym(input logic k, input logic [7:0] d, input logic [2:0] st, input logic v);
    Rx_DataK  = k;
    Rx_Data   = d;
    Rx_Status = st;
    Rx_Valid  = v;
    @(posedge PCLK);
    #1;
  endtask

  task automatic com();  sym(1'b1, 8'hBC, 3'b000, 1'b1); endtask
  task automatic skp();  sym(1'b1, 8'h1C, 3'b000, 1'b1); endtask
  task automatic dat(input logic [7:0] d, input logic push);
    if (push) exp_q.push_back({1'b0, d});
    sym(1'b0, d, 3'b000, 1'b1);
  endtask
  task automatic err();  sym(1'b0, 8'h00, 3'b100, 1'b1); endtask

  task automatic do_reset();
    Reset = 1'b1;
    exp_q.delete();
    Rx_Valid = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    Reset = 1'b0;
  endtask

  // Monitor: every accepted output beat must match the head of the scoreboard
  always @(negedge PCLK) begin
    if (!Reset && Out_Valid && Out_Ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %0h expected no output", {Out_DataK, Out_Data});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({Out_DataK, Out_Data} !== e) begin
          errors++;
          $display("FAIL out_data: got %0h expected %0h", {Out_DataK, Out_Data}, e);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; Rx_Data = 8'h00; Rx_DataK = 1'b0; Rx_Valid = 1'b0;
    Rx_Status = 3'b000; Out_Ready = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("rst_out_data",  32'(Out_Data),  32'd0);
    chk("rst_out_datak", 32'(Out_DataK), 32'd0);
    chk("rst_locked",    32'(Locked),    32'd0);
    chk("rst_err_count", 32'(Err_Count), 32'd0);
    chk("rst_overflow",  32'(Overflow),  32'd0);
    Reset = 1'b0;

    // Lock and pass-through
    Out_Ready = 1'b1;
    com();
    chk("lock_after_com1", 32'(Locked), 32'd0);
    com();
    chk("lock_after_com2", 32'(Locked), 32'd1);
    chk("locking_com_not_out", 32'(Out_Valid), 32'd0);
    dat(8'h4A, 1'b1);
    chk("lat_4a", {23'd0, Out_Valid, Out_Data}, {23'd0, 1'b1, 8'h4A});
    dat(8'h55, 1'b1);
    chk("lat_55", {23'd0, Out_Valid, Out_Data}, {23'd0, 1'b1, 8'h55});
    repeat (2) skp();
    chk("pass_drained", 32'(Out_Valid), 32'd0);

    // SKP stripping
    exp_q.push_back({1'b1, 8'hBC});
    com();
    repeat (3) skp();
    dat(8'h10, 1'b1);
    repeat (3) skp();
    chk("skp_drained", 32'(Out_Valid), 32'd0);
    chk("skp_locked", 32'(Locked), 32'd1);

    // Error run forces loss of lock
    repeat (3) err();
    chk("err3_locked", 32'(Locked), 32'd1);
    err();
    chk("err4_unlocked", 32'(Locked), 32'd0);
    chk("err4_count", 32'(Err_Count), 32'd4);
    chk("err_not_out", 32'(Out_Valid), 32'd0);

    // A good COM between errors keeps lock
    com(); com();
    chk("relock", 32'(Locked), 32'd1);
    repeat (3) err();
    exp_q.push_back({1'b1, 8'hBC});
    com();
    err();
    chk("com_keeps_lock", 32'(Locked), 32'd1);
    chk("err_count_8", 32'(Err_Count), 32'd8);
    repeat (3) skp();

    // Overflow: ten symbols into eight slots
    Out_Ready = 1'b0;
    for (int i = 0; i < 10; i++) dat(8'h20 + 8'(i), i < 8);
    chk("ovf_valid", 32'(Out_Valid), 32'd1);
    chk("ovf_flag", 32'(Overflow), 32'd1);
    Out_Ready = 1'b1;
    repeat (10) skp();
    chk("ovf_drained", 32'(Out_Valid), 32'd0);
    chk("ovf_sticky", 32'(Overflow), 32'd1);

    // Full FIFO with simultaneous read and write
    do_reset();
    chk("ovf_cleared", 32'(Overflow), 32'd0);
    com(); com();
    Out_Ready = 1'b0;
    for (int i = 0; i < 8; i++) dat(8'h30 + 8'(i), 1'b1);
    Out_Ready = 1'b1;
    dat(8'hA5, 1'b1);
    chk("full_rw_no_ovf", 32'(Overflow), 32'd0);
    repeat (10) skp();
    chk("full_rw_drained", 32'(Out_Valid), 32'd0);
    chk("full_rw_ovf_end", 32'(Overflow), 32'd0);

    // Reset mid-stream
    Out_Ready = 1'b0;
    repeat (3) err();
    for (int i = 0; i < 5; i++) dat(8'h60 + 8'(i), 1'b1);
    chk("pre_rst_errs", 32'(Err_Count), 32'd3);
    chk("pre_rst_valid", 32'(Out_Valid), 32'd1);
    #2;
    Reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid",  32'(Out_Valid), 32'd0);
    chk("mid_rst_data",   32'(Out_Data),  32'd0);
    chk("mid_rst_locked", 32'(Locked),    32'd0);
    chk("mid_rst_errs",   32'(Err_Count), 32'd0);
    @(posedge PCLK);
    #1;
    Reset = 1'b0;
    Out_Ready = 1'b1;
    com();
    chk("post_rst_com1", 32'(Locked), 32'd0);
    com();
    chk("post_rst_com2", 32'(Locked), 32'd1);
    chk("post_rst_empty", 32'(Out_Valid), 32'd0);

    Rx_Valid = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_mac_rx_receiver.md
Name: pipe_mac_rx_receiver

Overview:
- MAC-side consumer of the PHY receive path. Runs on PCLK and samples one 8-bit symbol per cycle from Rx_Data/Rx_DataK/Rx_Valid/Rx_Status.
- Acquires symbol lock on COM (K28.5) and strips SKP (K28.0).
- Drops and counts errored symbols; buffers clean symbols in a first-word-fall-through FIFO with a valid/ready handshake to MAC logic.
- Counterpart to the MAC TX path that drives MAC_TX_Data/MAC_TX_DataK into the PHY.

Parameters:
- FIFO_DEPTH, 8, FIFO entries (power of 2, >=2).
- LOCK_COM_COUNT, 2, consecutive good COMs needed to lock (1..15).
- ERR_LIMIT, 4, errored symbols without an intervening good COM that force loss of lock (1..15).

Ports:
- PCLK  in  1  clock; all logic rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Rx_Data  in  8  received symbol.
- Rx_DataK  in  1  1 = control symbol.
- Rx_Valid  in  1  PHY symbol valid.
- Rx_Status  in  3  PIPE RxStatus (000 ok, 001/010 SKP added/removed, 100 decode err, 101 EB overflow, 110 EB underflow, 111 disparity err).
- Out_Data  out  8  FIFO head symbol.
- Out_DataK  out  1  FIFO head K flag.
- Out_Valid  out  1  FIFO not empty.
- Out_Ready  in  1  consumer accepts head this cycle.
- Locked  out  1  FSM in LOCKED.
- Err_Count  out  16  saturating error counter.
- Overflow  out  1  sticky FIFO overflow flag.

Behaviour:
- Definitions:
  - Good = Rx_Valid & Rx_Status in {000,001,010}.
  - Err = Rx_Valid & Rx_Status in {100,101,110,111}.
  - COM = Good & Rx_DataK & Rx_Data==8'hBC.
  - SKP = Good & Rx_DataK & Rx_Data==8'h1C.
- Reset values:
  - Outputs: Out_Valid=0, Out_Data=0, Out_DataK=0, Locked=0, Err_Count=0, Overflow=0.
  - Internal: FIFO empty, state UNLOCKED, com_cnt=0, err_run=0.
- FSM has two states, UNLOCKED and LOCKED. Locked = (state==LOCKED).
- In UNLOCKED:
  - COM increments com_cnt.
  - Err or Rx_Valid=0 clears com_cnt.
  - Other Good symbols leave com_cnt unchanged.
  - When a COM brings com_cnt to LOCK_COM_COUNT: next state is LOCKED, com_cnt cleared, err_run cleared.
  - Nothing is written to the FIFO in UNLOCKED, including the locking COM.
- In LOCKED:
  - Rx_Valid=0 -> next state UNLOCKED.
  - Err increments err_run; reaching ERR_LIMIT -> next state UNLOCKED.
  - COM clears err_run. Other Good symbols leave err_run unchanged.
- FIFO write, evaluated on the registered state:
  - Occurs when state==LOCKED & Good & !SKP.
  - COM is written. SKP and Err symbols are never written.
- Err_Count increments by 1 on every Err cycle in either state. Saturates at 16'hFFFF.
- FIFO:
  - Read = Out_Valid & Out_Ready. Out_Data/Out_DataK show the head combinationally from storage.
  - A write into an empty FIFO appears on Out_Valid/Out_Data on the next cycle (1-cycle latency).
  - Full & write & !read: symbol dropped, Overflow set. Overflow is cleared only by Reset.
  - Full & write & read in the same cycle: write accepted, occupancy unchanged, no overflow.
  - Empty & Out_Ready: no effect.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is width clog2(FIFO_DEPTH)+1.
- Loss of lock does not flush the FIFO; queued symbols still drain.
- Reset asserted mid-operation immediately clears all state and the FIFO.

Optional Feature:
- Macro: PIPE_MAC_RX_LAST_ERR_EN.
- Defined: adds output Last_Err_Status[2:0], reset 3'b000, loaded with Rx_Status on every Err cycle, holds otherwise.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Lock and pass-through: COM, COM (status 000), then D 8'h4A, D 8'h55 with Out_Ready=1.
  - Locked rises the cycle after the 2nd COM.
  - Out_Data shows 8'h4A then 8'h55, each 1 cycle after input.
  - Neither locking COM is output.
- SKP strip: locked stream COM, SKP, SKP, SKP, D 8'h10 -> output sequence is 8'hBC (K=1) then 8'h10 only.
- Error handling (ERR_LIMIT=4): locked, then four consecutive symbols with Rx_Status=100.
  - Err_Count=4.
  - Locked falls the cycle after the 4th error.
  - No errored symbols are output.
  - Repeat with a COM after the 3rd error: lock is retained.
- Overflow (FIFO_DEPTH=8): locked, Out_Ready=0, 10 data symbols.
  - Out_Valid=1 with 8 entries; symbols 9 and 10 dropped; Overflow=1.
  - Then Out_Ready=1 drains exactly the first 8 symbols in order.
  - Overflow stays 1 until Reset.
- Full simultaneous read/write: FIFO full, Out_Ready=1, new symbol 8'hA5 arriving -> accepted, Overflow stays 0, 8'hA5 is the last symbol drained.
- Reset mid-stream: assert Reset with 5 entries queued and Err_Count=3 -> all outputs at reset values immediately; after release, 2 COMs are needed to relock.
